tow_cyber_player: RTL and testbench
===================================

// Module: tow_cyber_player
// PURPOSE
//  Computer opponent for the tug-of-war game. Produces single-cycle press pulses
//  at pseudo-random intervals; difficulty sets the press probability.
//  Sits directly upstream of tow_delegator's player2 input.
//  Contains its own LFSR, a threshold comparator and a rate-limit FSM, so the
//  pulse it emits obeys the same one-cycle press contract as tow_input's output.
// PARAMETERS
//  WIDTH     10        LFSR width in bits; level is WIDTH-1 bits wide.
//  TAPS      10'h240   feedback tap mask: bits 9 and 6, x^10+x^7+1, period 1023.
//  SEED      10'h001   LFSR reset value and lock-up reload value; must be nonzero.
//  COOLDOWN  3         cycles in COOL after each press; 0 is legal.
//  CNT_W     16        width of press_count; used only with TOW_CYBER_STATS_EN.
// PORTS
//  clk          in   1          game clock
//  reset        in   1          asynchronous, active-high reset
//  enable       in   1          1 = round in progress; tie to ~(reset|w1|w2)
//  level        in   WIDTH-1    difficulty; 0 = never press, max = most aggressive
//  press        out  1          one-cycle press pulse; registered
//  q            out  WIDTH      current LFSR state, for display and debug
//  press_count  out  CNT_W      saturating press count; 0 without TOW_CYBER_STATS_EN
// BEHAVIOUR
//  Reset (async, takes effect immediately, including mid-round):
//   - q=SEED, state=IDLE, press=0, cooldown counter=0, press_count=0.
//  LFSR:
//   - Advances every clk edge when not in reset, regardless of enable or state.
//   - q <= {q[WIDTH-2:0], ^(q & TAPS)}.
//   - If q==0 (lock-up), q <= SEED on the next edge instead of the shift.
//  Trigger (combinational):
//   - trig = ({1'b0,level} > q), unsigned compare.
//   - level==0 never triggers.
//  FSM (4 states, press is a Moore output, press = (state==FIRE)):
//   - IDLE:  enable=1 -> ARMED; otherwise stay.
//   - ARMED: trig=1 -> FIRE; otherwise stay.
//   - FIRE:  -> COOL and load cnt=COOLDOWN-1 when COOLDOWN>0;
//            -> ARMED when COOLDOWN==0.
//   - COOL:  cnt==0 -> ARMED; otherwise cnt <= cnt-1.
//   - enable=0 in any state -> IDLE on the next edge; this overrides all other
//     transitions. An in-flight FIRE still completes its current cycle.
//  Latency and spacing:
//   - trig sampled high in ARMED at edge k gives press=1 for exactly the cycle
//     after edge k.
//   - press is never high on two consecutive cycles.
//   - Minimum spacing between rising edges of press is COOLDOWN+2 cycles.
//  Simultaneous events:
//   - enable falling on the same edge as ARMED/trig -> IDLE, no press.
//   - reset dominates everything.
// CONFIGURATION
//  Macro TOW_CYBER_STATS_EN:
//   - Defined: press_count increments on every cycle with press=1 and saturates
//     at all-ones (no wrap). It is cleared only by reset; enable does not clear it.
//   - Undefined: no counter logic is built; press_count is tied to 0.
//   - The port list is identical in both builds.
// TESTING
//  1. Run, then assert reset mid-COOL -> same cycle: q=10'h001, press=0;
//     after release with enable=1 -> ARMED one edge later.
//  2. level=0, enable=1 for 2100 cycles -> press never 1; q visits 1023 distinct
//     nonzero values and returns to 10'h001 after 1023 edges.
//  3. level=9'h1FF, COOLDOWN=3, enable=1 -> every press pulse is 1 cycle wide;
//     successive rising edges are >=5 cycles apart; at least one pair is exactly 5.
//  4. COOLDOWN=0, level=9'h1FF -> no back-to-back press; minimum spacing is 2 cycles.
//  5. enable dropped in FIRE, then in ARMED with trig=1 -> FIRE pulse finishes,
//     then IDLE with no further press until enable returns; the ARMED case
//     produces no press.
//  6. TOW_CYBER_STATS_EN defined, CNT_W=4, level max, 200 cycles ->
//     press_count tracks the observed pulse count and then holds at 4'hF.
//     Macro undefined -> press_count stays 0.

Source files
------------

// File: rtl/tow_cyber_player.sv
// Computer opponent for tug-of-war: LFSR-driven press pulses, rate-limited by a cooldown FSM.
// Optional build macro TOW_CYBER_STATS_EN adds a saturating press counter on press_count.
module tow_cyber_player #(
    parameter int               WIDTH    = 10,
    parameter logic [WIDTH-1:0] TAPS     = 10'h240,
    parameter logic [WIDTH-1:0] SEED     = 10'h001,
    parameter int               COOLDOWN = 3,
    parameter int               CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-2:0] level,
    output logic             press,
    output logic [WIDTH-1:0] q,
    output logic [CNT_W-1:0] press_count
);

    localparam int CW = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        FIRE  = 2'd2,
        COOL  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             press_q, press_d;
    logic             trig;

    // An all-zero state would stick forever, so it reloads the seed instead.
    always_comb begin
        q_d = (q_q == '0) ? SEED : {q_q[WIDTH-2:0], ^(q_q & TAPS)};
    end

    assign trig = ({1'b0, level} > q_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (enable) state_d = ARMED;
            end
            ARMED: begin
                if (trig) state_d = FIRE;
            end
            FIRE: begin
                if (COOLDOWN == 0) begin
                    state_d = ARMED;
                end else begin
                    state_d = COOL;
                    cnt_d   = CW'(COOLDOWN - 1);
                end
            end
            COOL: begin
                if (cnt_q == '0) state_d = ARMED;
                else             cnt_d   = cnt_q - CW'(1);
            end
            default: state_d = IDLE;
        endcase
        // Dropping enable aborts whatever is pending; a FIRE already showing still lasts its cycle.
        if (!enable) state_d = IDLE;
        press_d = (state_d == FIRE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            q_q     <= SEED;
            press_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            press_q <= press_d;
        end
    end

    assign press = press_q;
    assign q     = q_q;

`ifdef TOW_CYBER_STATS_EN
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (press_q && (count_q != '1)) count_d = count_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) count_q <= '0;
        else       count_q <= count_d;
    end

    assign press_count = count_q;
`else
    assign press_count = '0;
`endif

endmodule

// File: tb/tb_tow_cyber_player.sv
// Directed bench for tow_cyber_player: reset, LFSR sequence, trigger boundary, cooldown spacing, enable drop.
// Runs a COOLDOWN=3 instance (CNT_W=4) and a COOLDOWN=0 instance side by side.
module tb_tow_cyber_player;

    localparam int W = 10;

    logic           clk = 1'b0;
    logic           rst;
    logic           enable;
    logic [W-2:0]   level;
    logic           press, press_c0;
    logic [W-1:0]   q, q_c0;
    logic [3:0]     cnt;
    logic [15:0]    cnt_c0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    tow_cyber_player #(.COOLDOWN(3), .CNT_W(4)) dut (
        .clk(clk), .reset(rst), .enable(enable), .level(level),
        .press(press), .q(q), .press_count(cnt)
    );

    tow_cyber_player #(.COOLDOWN(0)) dut_c0 (
        .clk(clk), .reset(rst), .enable(enable), .level(level),
        .press(press_c0), .q(q_c0), .press_count(cnt_c0)
    );

    // LFSR values after edges 1..9 from SEED=001 with taps at bits 9 and 6.
    logic [W-1:0] q_tbl [9] = '{10'h002, 10'h004, 10'h008, 10'h010, 10'h020,
                                10'h040, 10'h081, 10'h102, 10'h204};
    // With level=1FF: ARMED after edge 1, FIRE after 2, COOL 3..5, ARMED 6, FIRE 7, COOL 8..
    logic         p_tbl [9] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic restart(input logic [W-2:0] lvl);
        rst    = 1'b1;
        enable = 1'b0;
        tick();
        rst    = 1'b0;
        enable = 1'b1;
        level  = lvl;
    endtask

    initial begin
        int presses, zeros, distinct, first_ret;
        int b2b, min_gap, n5, last_rise, done;
        int b2b_c0, min_gap_c0, last_rise_c0, done_c0;
        logic prev, prev_c0;
        logic seen [1024];

        rst    = 1'b1;
        enable = 1'b0;
        level  = '0;
        repeat (2) tick();
        check("reset_q", 32'(q), 32'h001);
        check("reset_press", 32'(press), 32'h0);
        check("reset_count", 32'(cnt), 32'h0);
        check("reset_state", 32'(dut.state_q), 32'h0);

        // Directed run from seed: exact LFSR values and press timing.
        rst    = 1'b0;
        enable = 1'b1;
        level  = 9'h1FF;
        for (int i = 0; i < 9; i++) begin
            tick();
            check($sformatf("seq_q_%0d", i + 1), 32'(q), 32'(q_tbl[i]));
            check($sformatf("seq_press_%0d", i + 1), 32'(press), 32'(p_tbl[i]));
        end
        check("mid_cool_state", 32'(dut.state_q), 32'h3);

        // Asynchronous reset in the middle of a cycle.
        #3 rst = 1'b1;
        #1;
        check("async_rst_q", 32'(q), 32'h001);
        check("async_rst_press", 32'(press), 32'h0);
        check("async_rst_state", 32'(dut.state_q), 32'h0);
        tick();
        rst = 1'b0;
        tick();
        check("armed_after_rst", 32'(dut.state_q), 32'h1);
        check("armed_press", 32'(press), 32'h0);
        tick();
        check("fire_after_rst", 32'(press), 32'h1);

        // Enable dropped while FIRE is showing.
        enable = 1'b0;
        tick();
        check("drop_fire_press", 32'(press), 32'h0);
        check("drop_fire_state", 32'(dut.state_q), 32'h0);
        presses = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (press) presses++;
        end
        check("idle_no_press", 32'(presses), 32'h0);
        check("idle_state", 32'(dut.state_q), 32'h0);
        enable = 1'b1;
        tick();
        check("reenable_armed", 32'(dut.state_q), 32'h1);

        // Reset asserted while press is high.
        restart(9'h1FF);
        repeat (2) tick();
        check("pre_rst_fire", 32'(press), 32'h1);
        #3 rst = 1'b1;
        #1;
        check("rst_in_fire_press", 32'(press), 32'h0);
        check("rst_in_fire_q", 32'(q), 32'h001);

        // Enable dropped in ARMED on the same edge trig is high.
        tick();
        rst = 1'b0;
        tick();
        check("armed_trig_state", 32'(dut.state_q), 32'h1);
        enable = 1'b0;
        tick();
        check("armed_drop_press", 32'(press), 32'h0);
        check("armed_drop_state", 32'(dut.state_q), 32'h0);
        presses = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (press) presses++;
        end
        check("armed_drop_quiet", 32'(presses), 32'h0);

        // Trigger boundary: level equal to q must not fire, level one above must.
        restart(9'h002);
        presses = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (press) presses++;
        end
        check("level_eq_q_no_fire", 32'(presses), 32'h0);
        restart(9'h003);
        repeat (2) tick();
        check("level_gt_q_fire", 32'(press), 32'h1);

        // level=0: never press; LFSR period is 1023 over nonzero states.
        restart(9'h000);
        foreach (seen[i]) seen[i] = 1'b0;
        presses = 0; zeros = 0; distinct = 0; first_ret = 0;
        for (int k = 1; k <= 2100; k++) begin
            tick();
            if (press || press_c0) presses++;
            if (q == '0) zeros++;
            if (k <= 1023) begin
                if (!seen[q]) distinct++;
                seen[q] = 1'b1;
                if (q == 10'h001 && first_ret == 0) first_ret = k;
            end
        end
        check("level0_no_press", 32'(presses), 32'h0);
        check("lfsr_no_zero", 32'(zeros), 32'h0);
        check("lfsr_distinct", 32'(distinct), 32'd1023);
        check("lfsr_period", 32'(first_ret), 32'd1023);

        // Max level: pulse width and spacing for COOLDOWN=3 and COOLDOWN=0.
        restart(9'h1FF);
        b2b = 0; min_gap = 9999; n5 = 0; last_rise = -1; done = 0; prev = 1'b0;
        b2b_c0 = 0; min_gap_c0 = 9999; last_rise_c0 = -1; done_c0 = 0; prev_c0 = 1'b0;
        for (int k = 1; k <= 1500; k++) begin
            tick();
`ifdef TOW_CYBER_STATS_EN
            check("count_track", 32'(cnt), 32'((done > 15) ? 15 : done));
            check("count_track_c0", 32'(cnt_c0), 32'(done_c0));
`endif
            if (press && prev) b2b++;
            if (press && !prev) begin
                if (last_rise >= 0) begin
                    if (k - last_rise < min_gap) min_gap = k - last_rise;
                    if (k - last_rise == 5) n5++;
                end
                last_rise = k;
            end
            if (press) done++;
            prev = press;
            if (press_c0 && prev_c0) b2b_c0++;
            if (press_c0 && !prev_c0) begin
                if (last_rise_c0 >= 0 && k - last_rise_c0 < min_gap_c0) min_gap_c0 = k - last_rise_c0;
                last_rise_c0 = k;
            end
            if (press_c0) done_c0++;
            prev_c0 = press_c0;
        end
        check("cd3_no_back_to_back", 32'(b2b), 32'h0);
        check("cd3_min_gap", 32'(min_gap), 32'd5);
        check("cd3_gap5_seen", 32'(n5 > 0), 32'h1);
        check("cd3_pulses_seen", 32'(done > 15), 32'h1);
        check("cd0_no_back_to_back", 32'(b2b_c0), 32'h0);
        check("cd0_min_gap", 32'(min_gap_c0), 32'd2);

        enable = 1'b0;
        repeat (2) tick();
`ifdef TOW_CYBER_STATS_EN
        check("count_saturated", 32'(cnt), 32'hF);
        check("count_c0_final", 32'(cnt_c0), 32'(done_c0));
`else
        check("count_tied_zero", 32'(cnt), 32'h0);
        check("count_c0_tied_zero", 32'(cnt_c0), 32'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
